y86_decode_stage: RTL and testbench

//  Pipelined Y86-64 decode/register-read stage: decodes srcA/srcB/dstE/dstM from icode,rA,rB,

---
 rtl/y86_pkg.sv | 40 ++++
 rtl/y86_regfile.sv | 38 +++
 rtl/y86_decode_stage.sv | 107 ++++++++++
 tb/tb_y86_decode_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: Y86-64 instruction codes, RNONE and the register-specifier decode used by the decode stage.
package y86_pkg;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_CMOVXX = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    localparam logic [3:0] RNONE = 4'hF;

    function automatic logic [3:0] src_a(input logic [3:0] icode, input logic [3:0] ra, input logic [3:0] rsp);
        return (icode inside {I_CMOVXX, I_RMMOVQ, I_OPQ, I_PUSHQ}) ? ra :
               (icode inside {I_POPQ, I_RET}) ? rsp : RNONE;
    endfunction

    function automatic logic [3:0] src_b(input logic [3:0] icode, input logic [3:0] rb, input logic [3:0] rsp);
        return (icode inside {I_OPQ, I_RMMOVQ, I_MRMOVQ}) ? rb :
               (icode inside {I_PUSHQ, I_POPQ, I_CALL, I_RET}) ? rsp : RNONE;
    endfunction

    function automatic logic [3:0] dst_e(input logic [3:0] icode, input logic [3:0] rb, input logic [3:0] rsp);
        return (icode inside {I_CMOVXX, I_IRMOVQ, I_OPQ}) ? rb :
               (icode inside {I_PUSHQ, I_POPQ, I_CALL, I_RET}) ? rsp : RNONE;
    endfunction

    function automatic logic [3:0] dst_m(input logic [3:0] icode, input logic [3:0] ra);
        return (icode inside {I_MRMOVQ, I_POPQ}) ? ra : RNONE;
    endfunction

endpackage

// File: rtl/y86_regfile.sv
// y86_regfile: NREG x DATA_W register file, two write ports (M port wins on a tie), two async reads.
module y86_regfile #(
    parameter int DATA_W = 64,
    parameter int NREG   = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        we_id_i,
    input  logic [DATA_W-1:0] we_val_i,
    input  logic [3:0]        wm_id_i,
    input  logic [DATA_W-1:0] wm_val_i,
    input  logic [3:0]        ra_id_i,
    output logic [DATA_W-1:0] ra_val_o,
    input  logic [3:0]        rb_id_i,
    output logic [DATA_W-1:0] rb_val_o
);
    import y86_pkg::*;

    logic [DATA_W-1:0] regs_q [NREG];

    function automatic logic ok(input logic [3:0] id);
        return id != RNONE && 32'(id) < NREG;
    endfunction

    // M write is issued last so it overrides E when both target the same register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            if (ok(we_id_i)) regs_q[we_id_i] <= we_val_i;
            if (ok(wm_id_i)) regs_q[wm_id_i] <= wm_val_i;
        end
    end

    assign ra_val_o = ok(ra_id_i) ? regs_q[ra_id_i] : '0;
    assign rb_val_o = ok(rb_id_i) ? regs_q[rb_id_i] : '0;

endmodule

// File: rtl/y86_decode_stage.sv
// y86_decode_stage: Y86-64 decode/register-read with forwarding, load-use stall and a registered
// valid/ready output bundle.
module y86_decode_stage import y86_pkg::*; #(
    parameter int         DATA_W = 64,
    parameter int         NREG   = 15,
    parameter logic [3:0] RSP_ID = 4'd4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [3:0]        in_icode_i,
    input  logic [3:0]        in_ifun_i,
    input  logic [3:0]        in_rA_i,
    input  logic [3:0]        in_rB_i,
    input  logic [DATA_W-1:0] in_valC_i,
    input  logic [DATA_W-1:0] in_valP_i,
    input  logic [3:0]        ex_dstE_i,
    input  logic [DATA_W-1:0] ex_valE_i,
    input  logic [3:0]        ex_dstM_i,
    input  logic [3:0]        mem_dstE_i,
    input  logic [3:0]        mem_dstM_i,
    input  logic [DATA_W-1:0] mem_valE_i,
    input  logic [DATA_W-1:0] mem_valM_i,
    input  logic [3:0]        wb_dstE_i,
    input  logic [3:0]        wb_dstM_i,
    input  logic [DATA_W-1:0] wb_valE_i,
    input  logic [DATA_W-1:0] wb_valM_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [3:0]        out_icode_o,
    output logic [3:0]        out_ifun_o,
    output logic [DATA_W-1:0] out_valA_o,
    output logic [DATA_W-1:0] out_valB_o,
    output logic [DATA_W-1:0] out_valC_o,
    output logic [3:0]        out_dstE_o,
    output logic [3:0]        out_dstM_o,
    output logic [3:0]        out_srcA_o,
    output logic [3:0]        out_srcB_o,
    output logic              out_ins_err_o
);
    localparam int BW = 3 * DATA_W + 25;
    localparam logic [BW-1:0] BUNDLE_RST = {8'h00, {(3 * DATA_W){1'b0}}, 16'hFFFF, 1'b0};

    logic [3:0]        src_a_w, src_b_w, dst_e_w, dst_m_w;
    logic [DATA_W-1:0] rf_a, rf_b, val_a, val_b;
    logic              ins_err, hazard, accept;
    logic              valid_d, valid_q;
    logic [BW-1:0]     bundle_d, bundle_q;

    always_comb begin
        ins_err = in_icode_i > I_POPQ;
        src_a_w = ins_err ? RNONE : src_a(in_icode_i, in_rA_i, RSP_ID);
        src_b_w = ins_err ? RNONE : src_b(in_icode_i, in_rB_i, RSP_ID);
        dst_e_w = ins_err ? RNONE : dst_e(in_icode_i, in_rB_i, RSP_ID);
        dst_m_w = ins_err ? RNONE : dst_m(in_icode_i, in_rA_i);
    end

    y86_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_id_i  (wb_dstE_i),
        .we_val_i (wb_valE_i),
        .wm_id_i  (wb_dstM_i),
        .wm_val_i (wb_valM_i),
        .ra_id_i  (src_a_w),
        .ra_val_o (rf_a),
        .rb_id_i  (src_b_w),
        .rb_val_o (rf_b)
    );

    // Youngest producer first; writeback is forwarded because the regfile only updates at the edge
    function automatic logic [DATA_W-1:0] fwd(input logic [3:0] id, input logic [DATA_W-1:0] rf);
        return id == RNONE       ? '0         :
               id == ex_dstE_i   ? ex_valE_i  :
               id == mem_dstM_i  ? mem_valM_i :
               id == mem_dstE_i  ? mem_valE_i :
               id == wb_dstM_i   ? wb_valM_i  :
               id == wb_dstE_i   ? wb_valE_i  : rf;
    endfunction

    always_comb begin
        val_a = (in_icode_i inside {I_CALL, I_JXX}) ? in_valP_i : fwd(src_a_w, rf_a);
        val_b = fwd(src_b_w, rf_b);
        hazard = in_valid_i && ex_dstM_i != RNONE && (ex_dstM_i == src_a_w || ex_dstM_i == src_b_w);
        in_ready_o = (!valid_q || out_ready_i) && !hazard;
        accept = in_valid_i && in_ready_o;
        valid_d = accept || (valid_q && !out_ready_i);
        bundle_d = accept ? {in_icode_i, in_ifun_i, val_a, val_b, in_valC_i,
                             dst_e_w, dst_m_w, src_a_w, src_b_w, ins_err} : bundle_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            bundle_q <= BUNDLE_RST;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign out_valid_o = valid_q;
    assign {out_icode_o, out_ifun_o, out_valA_o, out_valB_o, out_valC_o,
            out_dstE_o, out_dstM_o, out_srcA_o, out_srcB_o, out_ins_err_o} = bundle_q;

endmodule

// File: tb/tb_y86_decode_stage.sv
// tb_y86_decode_stage: directed scenarios plus randomized traffic checked every cycle against a
// table-driven reference model of the decode stage.
module tb_y86_decode_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready, out_ready, out_valid, out_err;
    logic [3:0]  in_icode, in_ifun, in_rA, in_rB;
    logic [63:0] in_valC, in_valP;
    logic [3:0]  ex_dstE, ex_dstM, mem_dstE, mem_dstM, wb_dstE, wb_dstM;
    logic [63:0] ex_valE, mem_valE, mem_valM, wb_valE, wb_valM;
    logic [3:0]  out_icode, out_ifun, out_dstE, out_dstM, out_srcA, out_srcB;
    logic [63:0] out_valA, out_valB, out_valC;

    always #5 clk = ~clk;

    y86_decode_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_icode_i(in_icode), .in_ifun_i(in_ifun), .in_rA_i(in_rA), .in_rB_i(in_rB),
        .in_valC_i(in_valC), .in_valP_i(in_valP),
        .ex_dstE_i(ex_dstE), .ex_valE_i(ex_valE), .ex_dstM_i(ex_dstM),
        .mem_dstE_i(mem_dstE), .mem_dstM_i(mem_dstM), .mem_valE_i(mem_valE), .mem_valM_i(mem_valM),
        .wb_dstE_i(wb_dstE), .wb_dstM_i(wb_dstM), .wb_valE_i(wb_valE), .wb_valM_i(wb_valM),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_icode_o(out_icode), .out_ifun_o(out_ifun),
        .out_valA_o(out_valA), .out_valB_o(out_valB), .out_valC_o(out_valC),
        .out_dstE_o(out_dstE), .out_dstM_o(out_dstM), .out_srcA_o(out_srcA), .out_srcB_o(out_srcB),
        .out_ins_err_o(out_err)
    );

    int checks = 0;
    int failures = 0;

    // Per-icode role tables: bit n set means icode n uses that rule
    localparam logic [15:0] SA_RA = 16'h0454;  // cmov, rmmov, OPq, push
    localparam logic [15:0] SA_SP = 16'h0A00;  // ret, pop
    localparam logic [15:0] SB_RB = 16'h0070;  // rmmov, mrmov, OPq
    localparam logic [15:0] XX_SP = 16'h0F00;  // call, ret, push, pop
    localparam logic [15:0] DE_RB = 16'h004C;  // cmov, irmov, OPq
    localparam logic [15:0] DM_RA = 16'h0820;  // mrmov, pop

    logic [63:0] m_rf [16];
    logic        m_valid, m_err, c_err, c_ready;
    logic [3:0]  m_icode, m_ifun, m_dstE, m_dstM, m_srcA, m_srcB;
    logic [3:0]  c_dstE, c_dstM, c_srcA, c_srcB;
    logic [63:0] m_valA, m_valB, m_valC, c_valA, c_valB;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] pick(input logic [15:0] rmask, input logic [15:0] smask,
                                        input logic [3:0] code, input logic [3:0] r);
        return rmask[code] ? r : smask[code] ? 4'd4 : 4'hF;
    endfunction

    function automatic logic [63:0] operand(input logic [3:0] id);
        logic [3:0]  ids [5];
        logic [63:0] vals [5];
        ids  = '{ex_dstE, mem_dstM, mem_dstE, wb_dstM, wb_dstE};
        vals = '{ex_valE, mem_valM, mem_valE, wb_valM, wb_valE};
        if (id == 4'hF) return 64'h0;
        for (int i = 0; i < 5; i++) if (ids[i] == id) return vals[i];
        return m_rf[id];
    endfunction

    task automatic model_comb();
        c_err  = in_icode > 4'hB;
        c_srcA = c_err ? 4'hF : pick(SA_RA, SA_SP, in_icode, in_rA);
        c_srcB = c_err ? 4'hF : pick(SB_RB, XX_SP, in_icode, in_rB);
        c_dstE = c_err ? 4'hF : pick(DE_RB, XX_SP, in_icode, in_rB);
        c_dstM = c_err ? 4'hF : pick(DM_RA, 16'h0, in_icode, in_rA);
        c_valA = (in_icode == 4'h7 || in_icode == 4'h8) ? in_valP : operand(c_srcA);
        c_valB = operand(c_srcB);
        c_ready = (!m_valid || out_ready) &&
                  !(in_valid && ex_dstM != 4'hF && (ex_dstM == c_srcA || ex_dstM == c_srcB));
    endtask

    task automatic model_step();
        if (in_valid && c_ready) begin
            m_valid = 1'b1; m_icode = in_icode; m_ifun = in_ifun; m_err = c_err;
            m_valA = c_valA; m_valB = c_valB; m_valC = in_valC;
            m_dstE = c_dstE; m_dstM = c_dstM; m_srcA = c_srcA; m_srcB = c_srcB;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        if (wb_dstE < 4'd15) m_rf[wb_dstE] = wb_valE;
        if (wb_dstM < 4'd15) m_rf[wb_dstM] = wb_valM;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_rf[i] = 64'h0;
        m_valid = 1'b0; m_icode = 4'h0; m_ifun = 4'h0; m_err = 1'b0;
        m_valA = 64'h0; m_valB = 64'h0; m_valC = 64'h0;
        m_dstE = 4'hF; m_dstM = 4'hF; m_srcA = 4'hF; m_srcB = 4'hF;
    endtask

    // Called at a negedge with inputs already driven; returns at the following negedge
    task automatic tick();
        #1;
        model_comb();
        check("in_ready", 64'(in_ready), 64'(c_ready));
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("out_icode", 64'(out_icode), 64'(m_icode));
        check("out_ifun", 64'(out_ifun), 64'(m_ifun));
        check("out_valA", out_valA, m_valA);
        check("out_valB", out_valB, m_valB);
        check("out_valC", out_valC, m_valC);
        check("out_dstE", 64'(out_dstE), 64'(m_dstE));
        check("out_dstM", 64'(out_dstM), 64'(m_dstM));
        check("out_srcA", 64'(out_srcA), 64'(m_srcA));
        check("out_srcB", 64'(out_srcB), 64'(m_srcB));
        check("out_ins_err", 64'(out_err), 64'(m_err));
    endtask

    task automatic idle();
        in_valid = 1'b0; in_icode = 4'h1; in_ifun = 4'h0; in_rA = 4'hF; in_rB = 4'hF;
        in_valC = 64'h0; in_valP = 64'h0;
        ex_dstE = 4'hF; ex_dstM = 4'hF; mem_dstE = 4'hF; mem_dstM = 4'hF;
        wb_dstE = 4'hF; wb_dstM = 4'hF;
        ex_valE = 64'h0; mem_valE = 64'h0; mem_valM = 64'h0; wb_valE = 64'h0; wb_valM = 64'h0;
        out_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_dstE", 64'(out_dstE), 64'hF);
        check("rst_out_srcB", 64'(out_srcB), 64'hF);
        check("rst_out_valA", out_valA, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [3:0] rid();
        return ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
    endfunction

    task automatic randomize_inputs();
        in_valid = $urandom_range(0, 3) != 0;
        in_icode = 4'($urandom_range(0, 15));
        in_ifun  = 4'($urandom_range(0, 15));
        in_rA    = 4'($urandom_range(0, 15));
        in_rB    = 4'($urandom_range(0, 15));
        in_valC  = {$urandom, $urandom};
        in_valP  = {$urandom, $urandom};
        ex_dstE  = rid(); mem_dstE = rid(); mem_dstM = rid();
        ex_dstM  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
        wb_dstE  = $urandom_range(0, 1) ? 4'($urandom_range(0, 14)) : 4'hF;
        wb_dstM  = $urandom_range(0, 2) == 0 ? 4'($urandom_range(0, 14)) : 4'hF;
        ex_valE  = {$urandom, $urandom}; mem_valE = {$urandom, $urandom};
        mem_valM = {$urandom, $urandom}; wb_valE = {$urandom, $urandom};
        wb_valM  = {$urandom, $urandom};
        out_ready = $urandom_range(0, 3) != 0;
    endtask

    initial begin
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_valid", 64'(out_valid), 64'h0);
        check("reset_srcA", 64'(out_srcA), 64'hF);
        rst_n = 1'b1;

        // irmovq $5,%rdx then addq %rdx,%rbx with rdx forwarded from execute
        in_valid = 1'b1; in_icode = 4'h3; in_rB = 4'h2; in_valC = 64'h5;
        tick();
        check("irmov_dstE", 64'(out_dstE), 64'h2);
        check("irmov_srcA", 64'(out_srcA), 64'hF);
        in_icode = 4'h6; in_rA = 4'h2; in_rB = 4'h3; ex_dstE = 4'h2; ex_valE = 64'h5;
        tick();
        check("fwd_valA", out_valA, 64'h5);
        check("fwd_valB", out_valB, 64'h0);
        check("addq_dstE", 64'(out_dstE), 64'h3);

        // Same-cycle writes to r3 on both ports: valM must win
        idle(); wb_dstE = 4'h3; wb_valE = 64'h7; wb_dstM = 4'h3; wb_valM = 64'h9;
        tick();
        idle(); in_valid = 1'b1; in_icode = 4'h6; in_rA = 4'h3; in_rB = 4'h3;
        tick();
        check("wbtie_valA", out_valA, 64'h9);
        check("wbtie_valB", out_valB, 64'h9);

        // Load-use: mrmovq to %rax in execute, addq %rax,%rcx must stall one cycle
        idle(); in_valid = 1'b1; in_icode = 4'h6; in_rA = 4'h0; in_rB = 4'h1; ex_dstM = 4'h0;
        #1 check("hazard_ready", 64'(in_ready), 64'h0);
        tick();
        check("hazard_bubble", 64'(out_valid), 64'h0);
        ex_dstM = 4'hF; mem_dstM = 4'h0; mem_valM = 64'h1234;
        tick();
        check("hazard_valid", 64'(out_valid), 64'h1);
        check("hazard_valA", out_valA, 64'h1234);

        // pushq %rsi with rsp=0x100, then call
        idle(); wb_dstE = 4'h4; wb_valE = 64'h100;
        tick();
        idle(); in_valid = 1'b1; in_icode = 4'hA; in_rA = 4'h6;
        tick();
        check("push_srcA", 64'(out_srcA), 64'h6);
        check("push_srcB", 64'(out_srcB), 64'h4);
        check("push_dstE", 64'(out_dstE), 64'h4);
        check("push_dstM", 64'(out_dstM), 64'hF);
        check("push_valB", out_valB, 64'h100);
        in_icode = 4'h8; in_rA = 4'hF; in_valP = 64'h40;
        tick();
        check("call_valA", out_valA, 64'h40);
        check("call_dstE", 64'(out_dstE), 64'h4);

        // Back-pressure for three cycles with a second bundle waiting
        idle(); in_valid = 1'b1; in_icode = 4'h3; in_rB = 4'h1; in_valC = 64'hA1;
        tick();
        out_ready = 1'b0; in_valC = 64'hB2;
        for (int i = 0; i < 3; i++) begin
            #1 check("stall_ready", 64'(in_ready), 64'h0);
            tick();
            check("stall_valC", out_valC, 64'hA1);
            check("stall_valid", 64'(out_valid), 64'h1);
        end
        out_ready = 1'b1;
        tick();
        check("resume_valC", out_valC, 64'hB2);

        // Illegal icode passes through flagged, with no register ids
        idle(); in_valid = 1'b1; in_icode = 4'hC; in_rA = 4'h1; in_rB = 4'h2;
        tick();
        check("err_flag", 64'(out_err), 64'h1);
        check("err_dstE", 64'(out_dstE), 64'hF);
        check("err_srcA", 64'(out_srcA), 64'hF);

        // Reset mid-stream clears the register file
        idle();
        do_reset();
        in_valid = 1'b1; in_icode = 4'h6; in_rA = 4'h3; in_rB = 4'h4;
        tick();
        check("postrst_valA", out_valA, 64'h0);
        check("postrst_valB", out_valB, 64'h0);

        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                idle();
                do_reset();
            end
            randomize_inputs();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
